// File: rtl/cpu_controller_pkg.sv
// Shared types for the accumulator CPU controller: opcodes, phases, run state.
// Build option CTRL_SINGLE_STEP_EN (see cpu_controller) uses no extra types.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ctrl_state_t;

    localparam phase_t HLT_PHASE = OP_ADDR;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// 3-bit phase counter: async reset, count enable, synchronous clear (priority),
// o_wrap flags the enabled 7->0 step in the current cycle.
module cpu_controller_phase_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [2:0] o_phase,
    output logic       o_wrap
);

    logic [2:0] r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 3'd0;
        end else if (i_clr) begin
            r_phase <= 3'd0;
        end else if (i_en) begin
            r_phase <= r_phase + 3'd1;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = i_en && !i_clr && (r_phase == 3'd7);

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: 8-phase cycle decoded into datapath strobes, HALTED with resume,
// retired-instruction counter. Build option CTRL_SINGLE_STEP_EN adds input step_mode.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  opcode_t            opcode,
    input  logic               zero,
    input  logic               resume,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic               step_mode,
`endif
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               load_ir,
    output logic               load_ac,
    output logic               load_pc,
    output logic               inc_pc,
    output logic               halt,
    output phase_t             phase,
    output logic [COUNT_W-1:0] instr_count
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_nxt;
    logic               r_step_halt;
    logic [COUNT_W-1:0] r_count;
    logic [2:0]         w_phase_raw;
    phase_t             w_phase;
    logic               w_step;
    logic               w_hlt_entry;
    logic               w_step_entry;
    logic               w_resume;
    logic               w_cnt_en;
    logic               w_wrap;
    logic               w_retire;
    logic               w_aluop;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_step = step_mode;
`else
    assign w_step = 1'b0;
`endif

    assign w_phase      = phase_t'(w_phase_raw);
    assign w_hlt_entry  = (r_state == RUN) && (w_phase == HLT_PHASE) && (opcode == HLT);
    assign w_resume     = (r_state == HALTED) && resume;
    assign w_cnt_en     = (r_state == RUN) && !w_hlt_entry;
    assign w_step_entry = w_wrap && w_step;
    // A step-halt already retired its instruction on the wrap; an HLT retires on resume.
    assign w_retire     = w_wrap || (w_resume && !r_step_halt);
    assign w_aluop      = is_aluop(opcode);

    cpu_controller_phase_counter u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .i_clr   (w_resume),
        .o_phase (w_phase_raw),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_step_halt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_step_entry) begin
                r_step_halt <= 1'b1;
            end else if (w_hlt_entry || w_resume) begin
                r_step_halt <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_hlt_entry || w_step_entry) w_state_nxt = HALTED;
            HALTED:  if (resume) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        if (r_state == RUN) begin
            case (w_phase)
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR:  inc_pc = 1'b1;
                OP_FETCH: mem_rd = w_aluop;
                ALU_OP: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    load_pc = (opcode == JMP);
                    inc_pc  = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign halt        = (r_state == HALTED);
    assign phase       = w_phase;
    assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a behavioural model pushes expected outputs
// per cycle; they are popped and compared mid-cycle. Also drives a COUNT_W=4 copy.
module tb_cpu_controller;
    import cpu_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    opcode_t     opcode = LDA;
    logic        zero = 1'b0;
    logic        resume = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step_mode = 1'b0;
`endif

    logic        mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
    phase_t      phase;
    logic [15:0] instr_count;
    logic        b_mem_rd, b_mem_wr, b_load_ir, b_load_ac, b_load_pc, b_inc_pc, b_halt;
    phase_t      b_phase;
    logic [3:0]  b_instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] strb;
        logic [2:0] ph;
        logic       hl;
        int         cnt;
    } exp_t;
    exp_t sb_q[$];

    int   m_phase;
    logic m_halted;
    logic m_step_halt;
    int   m_cnt;

    always #5 clk = ~clk;

    cpu_controller #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode(step_mode),
`endif
        .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
        .load_pc(load_pc), .inc_pc(inc_pc), .halt(halt), .phase(phase),
        .instr_count(instr_count)
    );

    cpu_controller #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode(step_mode),
`endif
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .load_ir(b_load_ir), .load_ac(b_load_ac),
        .load_pc(b_load_pc), .inc_pc(b_inc_pc), .halt(b_halt), .phase(b_phase),
        .instr_count(b_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobe vector order: {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc}
    function automatic logic [5:0] exp_strobes(input logic halted, input int ph,
                                               input opcode_t op, input logic z);
        logic alu;
        logic rd, wr, ir, ac, lpc, ipc;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        {rd, wr, ir, ac, lpc, ipc} = 6'b0;
        if (!halted) begin
            case (ph)
                1: rd = 1'b1;
                2, 3: begin rd = 1'b1; ir = 1'b1; end
                4: ipc = 1'b1;
                5: rd = alu;
                6: begin rd = alu; ac = alu; ipc = (op == SKZ) && z; lpc = (op == JMP); end
                7: begin rd = alu; ac = alu; lpc = (op == JMP); ipc = (op == JMP); wr = (op == STO); end
                default: ;
            endcase
        end
        return {rd, wr, ir, ac, lpc, ipc};
    endfunction

    function automatic logic [5:0] got_strobes();
        return {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_halted = 1'b0; m_step_halt = 1'b0; m_cnt = 0;
    endtask

    task automatic model_update();
        logic stp;
        stp = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        stp = step_mode;
`endif
        if (!m_halted) begin
            if (m_phase == 4 && opcode == HLT) begin
                m_halted = 1'b1;
                m_step_halt = 1'b0;
            end else if (m_phase == 7) begin
                m_phase = 0;
                m_cnt++;
                if (stp) begin
                    m_halted = 1'b1;
                    m_step_halt = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end else if (resume) begin
            if (!m_step_halt) m_cnt++;
            m_halted = 1'b0;
            m_step_halt = 1'b0;
            m_phase = 0;
        end
    endtask

    // Called just after a posedge with inputs already set for the coming cycle.
    task automatic run_cycle();
        exp_t e;
        e.strb = exp_strobes(m_halted, m_phase, opcode, zero);
        e.ph   = 3'(m_phase);
        e.hl   = m_halted;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("strobes", {26'd0, got_strobes()}, {26'd0, e.strb});
        chk("phase", {29'd0, phase}, {29'd0, e.ph});
        chk("halt", {31'd0, halt}, {31'd0, e.hl});
        chk("count", {16'd0, instr_count}, 32'(e.cnt & 16'hFFFF));
        chk("count4", {28'd0, b_instr_count}, 32'(e.cnt & 4'hF));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic finish_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        chk("rst_strobes", {26'd0, got_strobes()}, 32'd0);
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        finish_reset();
        // We are now in phase 1; finish this instruction, then align on phase 0.
        opcode = LDA;
        run_n(7);
        chk("lda_first_count", {16'd0, instr_count}, 32'd1);
        run_n(16);
        chk("lda_count16", {16'd0, instr_count}, 32'd3);

        // resume while running must be ignored
        for (int i = 0; i < 8; i++) begin
            resume = (i == 2);
            run_cycle();
        end
        resume = 1'b0;

        opcode = SKZ; zero = 1'b1; run_n(8);
        zero = 1'b0; run_n(8);
        opcode = JMP; run_n(8);
        opcode = STO; run_n(8);
        opcode = AND; zero = 1'($urandom_range(1)); run_n(8);
        opcode = XOR; zero = 1'($urandom_range(1)); run_n(8);
        chk("count_pre_hlt", {16'd0, instr_count}, 32'd10);

        opcode = HLT; run_n(5);
        chk("hlt_halt", {31'd0, halt}, 32'd1);
        run_n(10);
        resume = 1'b1; run_cycle();
        resume = 1'b0;
        chk("resume_phase", {29'd0, phase}, 32'd0);
        chk("resume_halt", {31'd0, halt}, 32'd0);
        chk("hlt_retired", {16'd0, instr_count}, 32'd11);
        opcode = LDA; run_n(8);

        // asynchronous reset in phase 6 of ADD
        opcode = ADD; zero = 1'b0; run_n(6);
        #1;
        chk("pre_rst_load_ac", {31'd0, load_ac}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_strobes", {26'd0, got_strobes()}, 32'd0);
        chk("arst_phase", {29'd0, phase}, 32'd0);
        chk("arst_count", {16'd0, instr_count}, 32'd0);
        chk("arst_count4", {28'd0, b_instr_count}, 32'd0);
        finish_reset();
        opcode = LDA;
        run_n(7 + 8 * 15);
        chk("wrap_count16", {16'd0, instr_count}, 32'd16);
        chk("wrap_count4", {28'd0, b_instr_count}, 32'd0);

`ifdef CTRL_SINGLE_STEP_EN
        rst = 1'b1;
        #1;
        finish_reset();
        step_mode = 1'b1;
        run_n(7);
        chk("step_halt", {31'd0, halt}, 32'd1);
        chk("step_phase", {29'd0, phase}, 32'd0);
        chk("step_count", {16'd0, instr_count}, 32'd1);
        for (int s = 0; s < 3; s++) begin
            run_n(3);
            resume = 1'b1; run_cycle();
            resume = 1'b0;
            run_n(8);
            chk("step_each_halt", {31'd0, halt}, 32'd1);
            chk("step_each_count", {16'd0, instr_count}, 32'(s + 2));
        end
        step_mode = 1'b0;
        resume = 1'b1; run_cycle();
        resume = 1'b0;
        run_n(16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit accumulator CPU.
- Steps an 8-phase cycle per instruction and decodes opcode_t plus the ALU zero flag into memory, IR, accumulator and PC control strobes.
- Sits between the instruction register and the datapath (ALU, accumulator, PC, memory).
- Adds a registered HALTED state with resume, and a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  opcode_t (3)  opcode field of the instruction register.
- zero  input  1  ALU zero flag (accumulator == 0).
- resume  input  1  single-cycle pulse; leaves HALTED.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- load_ir  output  1  load instruction register.
- load_ac  output  1  load accumulator from ALU out.
- load_pc  output  1  load PC from IR operand.
- inc_pc  output  1  increment PC.
- halt  output  1  high while in HALTED.
- phase  output  3  current phase (phase_t).
- instr_count  output  COUNT_W  retired instructions, wraps.

Behaviour:
- Reset (async, rst=1): phase=INST_ADDR(0), state=RUN, instr_count=0, halt=0. All strobes decode to 0 in phase 0.
- RUN: phase increments by 1 per posedge, wrapping 7->0. instr_count increments by 1 on each 7->0 transition, wrapping at 2^COUNT_W-1 -> 0.
- Strobes are combinational decodes of (state, phase, opcode, zero). ALUOP = opcode in {ADD, AND, XOR, LDA}.
  - 0 INST_ADDR: all strobes 0.
  - 1 INST_FETCH: mem_rd=1.
  - 2 INST_LOAD: mem_rd=1, load_ir=1.
  - 3 IDLE: mem_rd=1, load_ir=1.
  - 4 OP_ADDR: inc_pc=1.
  - 5 OP_FETCH: mem_rd=ALUOP.
  - 6 ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
  - 7 STORE: mem_rd=ALUOP, load_ac=ALUOP, load_pc=(opcode==JMP), inc_pc=(opcode==JMP), mem_wr=(opcode==STO).
- HLT entry: in phase 4 with opcode==HLT, inc_pc=1 still asserts that cycle. At the next posedge, state=HALTED and phase holds at 4.
- HALTED:
  - halt=1; every strobe is 0 and phase is frozen.
  - resume=1 at a posedge: state=RUN, phase=0, halt=0 next cycle.
  - The HLT instruction counts as retired: instr_count increments on that same resume transition.
- resume while in RUN is ignored.
- rst during any phase or HALTED aborts immediately to reset values; no partial strobes afterwards.
- opcode must be stable from phase 3 through phase 7. zero is sampled combinationally in phase 6 only.
- SKZ with zero=0 and NOP-like opcodes (HLT excluded) produce no strobes in phases 5-7.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step_mode (1 bit).
  - When step_mode=1 in phase 7, the next posedge enters HALTED with phase=0 instead of wrapping to 0 in RUN. instr_count still increments on that transition.
  - resume then continues at phase 0.
  - A HALTED state entered via step does not increment instr_count again on resume.
- Undefined: port absent; behaves as step_mode=0.

Decomposition:
- Package typedefs gains:
  - phase_t: 3-bit enum INST_ADDR..STORE.
  - ctrl_state_t: RUN, HALTED.
  - function is_aluop(opcode_t).
  - localparam HLT_PHASE = OP_ADDR.
- One sub-module, phase_counter: 3-bit counter with async rst, enable, synchronous clear, wrap output. The controller instantiates it and owns the state FSM, decode and instr_count.

Test Plan:
- Reset then free-run, opcode=LDA: phases 0..7 repeat. mem_rd high in phases 1,2,3,5,6,7; load_ir in 2,3; load_ac in 6,7; inc_pc in 4; instr_count=2 after 16 cycles.
- opcode=SKZ: zero=1 gives inc_pc=1 in phase 6; zero=0 gives inc_pc=0 in phase 6. No mem_rd in 5-7 in either case.
- opcode=JMP: load_pc=1 in phases 6 and 7; inc_pc=1 in phase 7. opcode=STO: mem_wr=1 only in phase 7.
- opcode=HLT: inc_pc=1 in phase 4, then halt=1 with all strobes 0 and phase=4 for 10 cycles. resume pulse gives phase=0, halt=0, instr_count +1.
- rst asserted mid-phase 6 of an ADD: all strobes drop without waiting for a clock edge; phase=0, instr_count=0. Also check COUNT_W=4 wraps 15 -> 0 after 16 instructions.
- CTRL_SINGLE_STEP_EN with step_mode=1: halt rises after each phase 7, phase=0. Each resume runs exactly one 8-cycle instruction; instr_count advances by 1 per step.
